// File: rtl/config_dispatcher_if.sv
// Config request channel between the config manager and the dispatcher.
// The manager drives address/data/valid; the dispatcher answers with ready.
interface config_dispatcher_if #(
  parameter int AW = 4,
  parameter int DW = 14
) ();

  logic [AW-1:0] C_Addr;
  logic [DW-1:0] C_Data;
  logic          C_Valid;
  logic          C_Rdy;

  modport master (
    output C_Addr,
    output C_Data,
    output C_Valid,
    input  C_Rdy
  );

  modport slave (
    input  C_Addr,
    input  C_Data,
    input  C_Valid,
    output C_Rdy
  );

endinterface

// File: rtl/config_dispatcher.sv
// Routes config writes to UART or VGA, holding each one until the
// target can safely take it; bad addresses and stalls raise an error.
module config_dispatcher #(
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_DATA_WIDTH   = 14,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_VGA_COLOR   = 4'h0,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_UART_BAUD   = 4'h1,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_UART_PARITY = 4'h2,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_UART_STOP   = 4'h3,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_VGA_CONFIG  = 4'h4,
  parameter logic [C_ADDR_WIDTH-1:0] ADDR_VGA_QUADRAN = 4'h5
) (
  input  logic                    Clk,
  input  logic                    Rst,
  config_dispatcher_if.slave      cfg,
  input  logic                    UART_Busy,
  input  logic                    VGA_Frame_End,
  output logic                    U_Wr_En,
  output logic [C_ADDR_WIDTH-1:0] U_Addr,
  output logic [C_DATA_WIDTH-1:0] U_Data,
  output logic                    V_Wr_En,
  output logic [C_ADDR_WIDTH-1:0] V_Addr,
  output logic [C_DATA_WIDTH-1:0] V_Data,
  output logic [1:0]              Disp_Error,
  output logic                    Disp_Error_Valid
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_UART,
    WAIT_VGA,
    WRITE,
    ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    to_uart_q, to_uart_d;

  logic                    rdy_q, rdy_d;
  logic                    u_wr_q, u_wr_d;
  logic [C_ADDR_WIDTH-1:0] u_addr_q, u_addr_d;
  logic [C_DATA_WIDTH-1:0] u_data_q, u_data_d;
  logic                    v_wr_q, v_wr_d;
  logic [C_ADDR_WIDTH-1:0] v_addr_q, v_addr_d;
  logic [C_DATA_WIDTH-1:0] v_data_q, v_data_d;
  logic [1:0]              err_q, err_d;
  logic                    err_vld_q, err_vld_d;

  logic is_color;
  logic is_uart;
  logic is_vga;

  assign is_color = (cfg.C_Addr == ADDR_VGA_COLOR);
  assign is_uart  = (cfg.C_Addr == ADDR_UART_BAUD)
                  | (cfg.C_Addr == ADDR_UART_PARITY)
                  | (cfg.C_Addr == ADDR_UART_STOP);
  assign is_vga   = (cfg.C_Addr == ADDR_VGA_CONFIG)
                  | (cfg.C_Addr == ADDR_VGA_QUADRAN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    to_uart_d = to_uart_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (cfg.C_Valid) begin
          addr_d = cfg.C_Addr;
          data_d = cfg.C_Data;
          cnt_d  = '0;
          unique case (1'b1)
            is_color: begin
              state_d   = WRITE;
              to_uart_d = 1'b0;
            end
            is_uart: begin
              state_d   = WAIT_UART;
              to_uart_d = 1'b1;
            end
            is_vga: begin
              state_d   = WAIT_VGA;
              to_uart_d = 1'b0;
            end
            default: begin
              state_d = ERR;
              err_d   = 2'b01;
            end
          endcase
        end
      end
      WAIT_UART: begin
        cnt_d = cnt_q + 1'b1;
        // an apply window in the last cycle still beats the timeout
        if (!UART_Busy) begin
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          err_d   = 2'b10;
        end
      end
      WAIT_VGA: begin
        cnt_d = cnt_q + 1'b1;
        if (VGA_Frame_End) begin
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          err_d   = 2'b10;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d   = IDLE;
        addr_d    = '0;
        data_d    = '0;
        to_uart_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they land registered
  always_comb begin
    rdy_d     = (state_d == IDLE);
    u_wr_d    = (state_d == WRITE) && to_uart_d;
    v_wr_d    = (state_d == WRITE) && !to_uart_d;
    u_addr_d  = u_wr_d ? addr_d : u_addr_q;
    u_data_d  = u_wr_d ? data_d : u_data_q;
    v_addr_d  = v_wr_d ? addr_d : v_addr_q;
    v_data_d  = v_wr_d ? data_d : v_data_q;
    err_vld_d = (state_d == ERR);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      to_uart_q <= 1'b0;
      rdy_q     <= 1'b1;
      u_wr_q    <= 1'b0;
      u_addr_q  <= '0;
      u_data_q  <= '0;
      v_wr_q    <= 1'b0;
      v_addr_q  <= '0;
      v_data_q  <= '0;
      err_q     <= 2'b00;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      to_uart_q <= to_uart_d;
      rdy_q     <= rdy_d;
      u_wr_q    <= u_wr_d;
      u_addr_q  <= u_addr_d;
      u_data_q  <= u_data_d;
      v_wr_q    <= v_wr_d;
      v_addr_q  <= v_addr_d;
      v_data_q  <= v_data_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
    end
  end

  assign cfg.C_Rdy        = rdy_q;
  assign U_Wr_En          = u_wr_q;
  assign U_Addr           = u_addr_q;
  assign U_Data           = u_data_q;
  assign V_Wr_En          = v_wr_q;
  assign V_Addr           = v_addr_q;
  assign V_Data           = v_data_q;
  assign Disp_Error       = err_q;
  assign Disp_Error_Valid = err_vld_q;

endmodule

// File: tb/tb_config_dispatcher.sv
// Randomized bench for config_dispatcher against a transaction-level model.
// Two instances: the default 1024-cycle timeout and a short 16-cycle one.
module tb_config_dispatcher;

  localparam int AW = 4;
  localparam int DW = 14;
  localparam int TA = 1024;
  localparam int TB = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_data = '0;
  logic          c_valid = 1'b0;
  logic          busy = 1'b0;
  logic          fe = 1'b0;

  config_dispatcher_if #(.AW(AW), .DW(DW)) cfg_a ();
  config_dispatcher_if #(.AW(AW), .DW(DW)) cfg_b ();

  assign cfg_a.C_Addr  = c_addr;
  assign cfg_a.C_Data  = c_data;
  assign cfg_a.C_Valid = c_valid;
  assign cfg_b.C_Addr  = c_addr;
  assign cfg_b.C_Data  = c_data;
  assign cfg_b.C_Valid = c_valid;

  logic          uw_a, vw_a, ev_a, uw_b, vw_b, ev_b;
  logic [AW-1:0] ua_a, va_a, ua_b, va_b;
  logic [DW-1:0] ud_a, vd_a, ud_b, vd_b;
  logic [1:0]    er_a, er_b;

  config_dispatcher #(.TIMEOUT_CYCLES(TA)) dut_a (
    .Clk(Clk), .Rst(Rst), .cfg(cfg_a),
    .UART_Busy(busy), .VGA_Frame_End(fe),
    .U_Wr_En(uw_a), .U_Addr(ua_a), .U_Data(ud_a),
    .V_Wr_En(vw_a), .V_Addr(va_a), .V_Data(vd_a),
    .Disp_Error(er_a), .Disp_Error_Valid(ev_a)
  );

  config_dispatcher #(.TIMEOUT_CYCLES(TB)) dut_b (
    .Clk(Clk), .Rst(Rst), .cfg(cfg_b),
    .UART_Busy(busy), .VGA_Frame_End(fe),
    .U_Wr_En(uw_b), .U_Addr(ua_b), .U_Data(ud_b),
    .V_Wr_En(vw_b), .V_Addr(va_b), .V_Data(vd_b),
    .Disp_Error(er_b), .Disp_Error_Valid(ev_b)
  );

  logic [41:0] vec_a, vec_b;
  assign vec_a = {cfg_a.C_Rdy, uw_a, vw_a, ev_a, er_a,
                  ua_a, ud_a, va_a, vd_a};
  assign vec_b = {cfg_b.C_Rdy, uw_b, vw_b, ev_b, er_b,
                  ua_b, ud_b, va_b, vd_b};

  initial forever #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;
  int tn     = 0;
  bit sel    = 1'b0;

  // model: last applied target values and last error code
  logic [AW-1:0] m_ua, m_va;
  logic [DW-1:0] m_ud, m_vd;
  logic [1:0]    m_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return sel ? {22'b0, vec_b} : {22'b0, vec_a};
  endfunction

  function automatic logic [63:0] ev(input bit rdy, input bit uw,
                                     input bit vw, input bit erv);
    return {22'b0, rdy, uw, vw, erv, m_err,
            m_ua, m_ud, m_va, m_vd};
  endfunction

  task automatic model_rst();
    m_ua = '0; m_ud = '0; m_va = '0; m_vd = '0; m_err = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; c_valid = 1'b0; busy = 1'b0; fe = 1'b0;
    #1;
    model_rst();
    chk("rst_async", obs(), ev(1, 0, 0, 0));
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_idle", obs(), ev(1, 0, 0, 0));
  endtask

  // d: wait-cycle index in which the apply condition is offered
  task automatic run_txn(input logic [AW-1:0] a,
                         input logic [DW-1:0] dat,
                         input int d, input bit fe0);
    int  t, k;
    bit  wr, isu, isv;
    logic [1:0] code;
    t    = sel ? TB : TA;
    isu  = (a >= 4'd1) && (a <= 4'd3);
    isv  = (a == 4'd4) || (a == 4'd5);
    wr   = 1'b0;
    code = 2'b00;
    if (a == 4'd0) begin
      k = 0; wr = 1'b1;
    end else if (!isu && !isv) begin
      k = 0; code = 2'b01;
    end else if (d <= t - 1) begin
      k = d + 1; wr = 1'b1;
    end else begin
      k = t; code = 2'b10;
    end
    tn++;
    c_valid = 1'b1; c_addr = a; c_data = dat;
    busy = 1'($urandom); fe = fe0;
    for (int c = 0; c <= k + 1; c++) begin
      @(negedge Clk);
      if (c == k) begin
        if (wr && isu) begin m_ua = a; m_ud = dat; end
        if (wr && !isu) begin m_va = a; m_vd = dat; end
        if (!wr) m_err = code;
      end
      chk($sformatf("t%0d_a%0d_c%0d", tn, a, c), obs(),
          ev(c == k + 1, c == k && wr && isu,
             c == k && wr && !isu, c == k && !wr));
      c_valid = (c <= k) ? 1'($urandom) : 1'b0;
      c_addr  = 4'($urandom);
      c_data  = 14'($urandom);
      busy    = isu ? (c < d) : 1'($urandom);
      fe      = isv ? (c == d) : 1'($urandom);
    end
    c_valid = 1'b0;
  endtask

  task automatic rand_txn(input int dmax);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15))
                                    : 4'($urandom_range(0, 5));
    run_txn(a, 14'($urandom), $urandom_range(0, dmax),
            1'($urandom));
  endtask

  task automatic rst_mid_wait();
    c_valid = 1'b1; c_addr = 4'd4; c_data = 14'h2A5;
    busy = 1'b0; fe = 1'b0;
    @(negedge Clk);
    c_valid = 1'b0;
    chk("rm_wait", obs(), ev(0, 0, 0, 0));
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    model_rst();
    chk("rm_in_rst", obs(), ev(1, 0, 0, 0));
    @(negedge Clk);
    Rst = 1'b0; fe = 1'b1;
    @(negedge Clk);
    fe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rm_after%0d", i), obs(), ev(1, 0, 0, 0));
      @(negedge Clk);
    end
  endtask

  initial begin
    sel = 1'b0;
    model_rst();
    do_reset();
    run_txn(4'd0, 14'h1ABC, 0, 1'b0);
    run_txn(4'd1, 14'd3, 20, 1'b0);
    run_txn(4'd4, 14'h0321, 49, 1'b1);
    run_txn(4'd9, 14'h3FFF, 0, 1'b0);
    run_txn(4'd5, 14'h1111, TA - 1, 1'b0);
    run_txn(4'd3, 14'h2222, TA, 1'b0);
    run_txn(4'd2, 14'h0777, 0, 1'b1);
    for (int i = 0; i < 80; i++) rand_txn(40);
    rst_mid_wait();
    run_txn(4'd0, 14'h0ACE, 0, 1'b0);

    sel = 1'b1;
    do_reset();
    run_txn(4'd2, 14'h0055, 100, 1'b0);
    run_txn(4'd1, 14'h0066, TB - 1, 1'b0);
    run_txn(4'd4, 14'h0077, TB, 1'b1);
    run_txn(4'd15, 14'h0088, 0, 1'b0);
    for (int i = 0; i < 60; i++) rand_txn(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
